// File: rtl/rf_multiport.sv
//==============================================================================
// Module      : rf_multiport
// Description : Parametrised multi-port register file. NREAD combinational
//               read ports, two write ports (port B wins on a collision),
//               asynchronous clear, optional hardwired zero register,
//               optional same-cycle write-through bypass and per-register
//               "written since reset" flags.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rf_multiport #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   w,
  input  logic [AW-1:0]          wn,
  input  logic [WIDTH-1:0]       wd,
  input  logic                   w2,
  input  logic [AW-1:0]          wn2,
  input  logic [WIDTH-1:0]       wd2,
  input  logic [NREAD*AW-1:0]    rn,
  output logic [NREAD*WIDTH-1:0] rd,
  output logic [NREAD-1:0]       rdv
);

  // Register storage and "written since reset" flags
  logic [WIDTH-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0] r_flag;

  // Qualified write strobes: enabled, in range, and not aimed at the
  // hardwired zero register. Shared by the array update and the bypass.
  logic w_wa_ok;
  logic w_wb_ok;

  assign w_wa_ok = w  && (32'(wn)  < DEPTH) && !((ZERO_REG != 0) && (wn  == '0));
  assign w_wb_ok = w2 && (32'(wn2) < DEPTH) && !((ZERO_REG != 0) && (wn2 == '0));

  // Array and flag update; async clear wins over any coincident write edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
      // Register 0 counts as "written" when it is the hardwired zero
      r_flag <= {{(DEPTH-1){1'b0}}, (ZERO_REG != 0)};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_wb_ok && (wn2 == AW'(i))) begin
          r_regs[i] <= wd2;
          r_flag[i] <= 1'b1;
        end else if (w_wa_ok && (wn == AW'(i))) begin
          r_regs[i] <= wd;
          r_flag[i] <= 1'b1;
        end
      end
    end
  end

  // One independent combinational read mux per port
  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0]    w_rn;
    logic [WIDTH-1:0] w_rd;
    logic             w_rdv;

    assign w_rn = rn[k*AW +: AW];

    // Select stored value, then apply zero-register and bypass overrides
    always_comb begin
      w_rd  = '0;
      w_rdv = 1'b0;
      // Out-of-range numbers match no entry and fall through as 0/0
      for (int j = 0; j < DEPTH; j++) begin
        if (w_rn == AW'(j)) begin
          w_rd  = r_regs[j];
          w_rdv = r_flag[j];
        end
      end
      if ((ZERO_REG != 0) && (w_rn == '0)) begin
        w_rd  = '0;
        w_rdv = 1'b1;
      end
      // Forward the data about to be committed; port B has priority as in
      // the array update. The ok strobes already exclude reg 0 and
      // out-of-range targets. Disabled while reset holds the array clear.
      if ((BYPASS != 0) && !reset) begin
        if (w_wb_ok && (wn2 == w_rn)) begin
          w_rd  = wd2;
          w_rdv = 1'b1;
        end else if (w_wa_ok && (wn == w_rn)) begin
          w_rd  = wd;
          w_rdv = 1'b1;
        end
      end
    end

    assign rd[k*WIDTH +: WIDTH] = w_rd;
    assign rdv[k]               = w_rdv;
  end

endmodule

`default_nettype wire

// File: tb/tb_rf_multiport.sv
//==============================================================================
// Module      : tb_rf_multiport
// Description : Self-checking bench for rf_multiport. Three instances share
//               one stimulus: default (bypass on), bypass off, DEPTH=20.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_rf_multiport;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        w     = 1'b0;
  logic [4:0]  wn    = '0;
  logic [31:0] wd    = '0;
  logic        w2    = 1'b0;
  logic [4:0]  wn2   = '0;
  logic [31:0] wd2   = '0;
  logic [4:0]  rn0   = '0;
  logic [4:0]  rn1   = '0;
  logic [9:0]  rn;
  logic [63:0] rd_a, rd_b, rd_c;
  logic [1:0]  rdv_a, rdv_b, rdv_c;

  int n_tests = 0;
  int n_fail  = 0;

  assign rn = {rn1, rn0};

  always #5 clk = ~clk;

  rf_multiport u_a (
    .clk(clk), .reset(reset), .w(w), .wn(wn), .wd(wd), .w2(w2), .wn2(wn2),
    .wd2(wd2), .rn(rn), .rd(rd_a), .rdv(rdv_a)
  );

  rf_multiport #(.BYPASS(0)) u_b (
    .clk(clk), .reset(reset), .w(w), .wn(wn), .wd(wd), .w2(w2), .wn2(wn2),
    .wd2(wd2), .rn(rn), .rd(rd_b), .rdv(rdv_b)
  );

  rf_multiport #(.DEPTH(20)) u_c (
    .clk(clk), .reset(reset), .w(w), .wn(wn), .wd(wd), .w2(w2), .wn2(wn2),
    .wd2(wd2), .rn(rn), .rd(rd_c), .rdv(rdv_c)
  );

  typedef struct {
    logic [31:0] w, wn, wd, w2, wn2, wd2, rn0, rn1;
    logic [31:0] a0, a1, av;   // default instance
    logic [31:0] b0, b1, bv;   // bypass-off instance
    logic [31:0] c0, c1, cv;   // DEPTH=20 instance
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_inst(input string nm, input logic [63:0] rdx, input logic [1:0] rdvx,
                          input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] ev);
    chk({nm, ".rd0"}, rdx[31:0], e0);
    chk({nm, ".rd1"}, rdx[63:32], e1);
    chk({nm, ".rdv"}, {30'b0, rdvx}, ev);
  endtask

  initial begin
    // State entering the table: reg i = i*i for every writable in-range reg
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 7, 31,   49, 961, 3,   49, 961, 3,   49, 0, 1};
    vecs[1]  = '{0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 3,      0, 0, 3,      0, 0, 3};
    vecs[2]  = '{1, 3, 32'hDEADBEEF, 0, 0, 0, 3, 4,
                 32'hDEADBEEF, 16, 3,  9, 16, 3,  32'hDEADBEEF, 16, 3};
    vecs[3]  = '{0, 0, 0, 0, 0, 0, 3, 3,
                 32'hDEADBEEF, 32'hDEADBEEF, 3, 32'hDEADBEEF, 32'hDEADBEEF, 3,
                 32'hDEADBEEF, 32'hDEADBEEF, 3};
    vecs[4]  = '{1, 5, 32'h11, 1, 5, 32'h22, 5, 6,
                 32'h22, 36, 3,  25, 36, 3,  32'h22, 36, 3};
    vecs[5]  = '{1, 6, 32'h11, 1, 9, 32'h22, 5, 9,
                 32'h22, 32'h22, 3,  32'h22, 81, 3,  32'h22, 32'h22, 3};
    vecs[6]  = '{0, 0, 0, 0, 0, 0, 6, 9,
                 32'h11, 32'h22, 3,  32'h11, 32'h22, 3,  32'h11, 32'h22, 3};
    vecs[7]  = '{1, 25, 7, 0, 0, 0, 25, 19,  7, 361, 3,  625, 361, 3,  0, 361, 2};
    vecs[8]  = '{0, 0, 0, 0, 0, 0, 25, 0,    7, 0, 3,    7, 0, 3,      0, 0, 2};
    vecs[9]  = '{1, 0, 55, 1, 0, 66, 0, 1,   0, 1, 3,    0, 1, 3,      0, 1, 3};
    vecs[10] = '{0, 0, 0, 0, 0, 0, 0, 2,     0, 4, 3,    0, 4, 3,      0, 4, 3};

    // Asynchronous reset, asserted between edges
    #1 reset = 1'b1;
    rn0 = 5'd1; rn1 = 5'd2;
    #1;
    chk_inst("rst.a.rn12", rd_a, rdv_a, 0, 0, 0);
    rn0 = 5'd0; rn1 = 5'd0;
    #1;
    chk_inst("rst.a.rn00", rd_a, rdv_a, 0, 0, 3);
    @(negedge clk);
    reset = 1'b0;
    rn0 = 5'd1; rn1 = 5'd2;
    #1;
    chk_inst("post_rst.a", rd_a, rdv_a, 0, 0, 0);
    chk_inst("post_rst.c", rd_c, rdv_c, 0, 0, 0);

    // Fill: reg i <= i*i, one edge each
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      w  = 1'b1;
      wn = 5'(i);
      wd = 32'(i * i);
    end

    // Table: check combinationally before the edge, edge commits the row
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      w   = vecs[i].w[0];   wn  = vecs[i].wn[4:0];  wd  = vecs[i].wd;
      w2  = vecs[i].w2[0];  wn2 = vecs[i].wn2[4:0]; wd2 = vecs[i].wd2;
      rn0 = vecs[i].rn0[4:0];
      rn1 = vecs[i].rn1[4:0];
      #1;
      chk_inst($sformatf("row%0d.a", i), rd_a, rdv_a, vecs[i].a0, vecs[i].a1, vecs[i].av);
      chk_inst($sformatf("row%0d.b", i), rd_b, rdv_b, vecs[i].b0, vecs[i].b1, vecs[i].bv);
      chk_inst($sformatf("row%0d.c", i), rd_c, rdv_c, vecs[i].c0, vecs[i].c1, vecs[i].cv);
    end

    // Reset mid-operation with a pending write to reg 4
    @(negedge clk);
    w = 1'b1; wn = 5'd4; wd = 32'd99; w2 = 1'b0;
    rn0 = 5'd4; rn1 = 5'd0;
    reset = 1'b1;
    #1;
    chk_inst("midrst.a", rd_a, rdv_a, 0, 0, 2);
    chk_inst("midrst.b", rd_b, rdv_b, 0, 0, 2);
    @(posedge clk);
    #1;
    chk_inst("midrst_edge.a", rd_a, rdv_a, 0, 0, 2);
    chk_inst("midrst_edge.b", rd_b, rdv_b, 0, 0, 2);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_inst("rst_rel.a", rd_a, rdv_a, 99, 0, 3);
    chk_inst("rst_rel.b", rd_b, rdv_b, 0, 0, 2);
    @(posedge clk);
    #1;
    chk_inst("rst_wr.b", rd_b, rdv_b, 99, 0, 3);
    @(negedge clk);
    w = 1'b0;
    #1;
    chk_inst("rst_wr.a", rd_a, rdv_a, 99, 0, 3);
    chk_inst("rst_wr.c", rd_c, rdv_c, 99, 0, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rf_multiport.md
Name: rf_multiport

Overview:
- Parametrised successor to the 2-read/1-write register file.
- Generalised in width, depth and read-port count; adds a second write port with fixed priority.
- Adds asynchronous clear, optional hardwired zero register, optional write-through bypass, and per-register "written since reset" flags.
- Sits in the datapath between decode (register numbers) and the ALU/writeback stage.

Parameters:
- WIDTH, 32, data bits per register.
- DEPTH, 32, number of registers; any value 2..2^AW.
- AW, 5, register-number width.
- NREAD, 2, number of read ports (1..8).
- ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes.
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports.

Ports:
- clk  in  1  Clock; all state changes on the rising edge.
- reset  in  1  Asynchronous, active-high reset.
- w  in  1  Write enable, port A.
- wn  in  AW  Register number, port A.
- wd  in  WIDTH  Write data, port A.
- w2  in  1  Write enable, port B.
- wn2  in  AW  Register number, port B.
- wd2  in  WIDTH  Write data, port B.
- rn  in  NREAD*AW  Packed read register numbers; port k is rn[k*AW +: AW].
- rd  out  NREAD*WIDTH  Packed read data; port k is rd[k*WIDTH +: WIDTH].
- rdv  out  NREAD  Per read port: 1 = addressed register written since reset.

Behaviour:
- Reset, asynchronous:
  - On assertion, all registers clear to 0 immediately, independent of clk.
  - All written flags clear to 0; flag of reg 0 is 1 when ZERO_REG=1.
  - While reset is high, writes are ignored, bypass is disabled, rd reflects the cleared array (all 0), and rdv reflects the flags.
  - A write whose clock edge coincides with reset high is lost.
- Write:
  - On rising clk edge, port A commits wd to reg[wn] when w=1, wn<DEPTH, and not (ZERO_REG=1 and wn=0); that reg's flag sets to 1.
  - Port B follows the same rules with w2/wn2/wd2.
  - Both ports may write different registers in the same edge.
  - Same register on both ports: port B data wins; flag set.
  - Disabled or out-of-range writes have no effect.
- Read (combinational, zero latency):
  - Each port k independently: rd_k = reg[rn_k], rdv_k = flag[rn_k].
  - rn_k >= DEPTH gives rd_k = 0, rdv_k = 0.
  - ZERO_REG=1 and rn_k = 0 gives rd_k = 0, rdv_k = 1.
- Bypass (BYPASS=1, reset low):
  - If w2=1 and wn2=rn_k (valid, writable), rd_k = wd2.
  - Else if w=1 and wn=rn_k (valid, writable), rd_k = wd.
  - Either case gives rdv_k = 1.
  - Never bypasses to reg 0 when ZERO_REG=1.
- BYPASS=0: reads show the pre-edge value; new data is visible after the rising edge.
- Any number of read ports may address the same register; they return identical values.
- No internal state besides the register array and flags; no FSM beyond edge-triggered update.

Test Plan:
- Reset, then read rn = {1,2} -> rd = {0,0}, rdv = {0,0}; rn = {0,0} with ZERO_REG=1 -> rd = 0, rdv = 1.
- Loop i=0..31: w=1, wn=i, wd=i*i, one edge each; then rn = {7,31} -> rd = {49,961}, rdv = {1,1}; rn = 0 -> rd = 0 (ZERO_REG=1).
- Same edge: w=1 wn=5 wd=0x11, w2=1 wn2=5 wd2=0x22 -> reg5 reads 0x22. Separate edge: wn=6/wn2=9 -> reg6 = 0x11 and reg9 = 0x22 both committed.
- Bypass: BYPASS=1, rn_0=3, w=1 wn=3 wd=0xDEADBEEF before the edge -> rd_0 = 0xDEADBEEF same cycle. BYPASS=0 -> old value until the edge, then 0xDEADBEEF.
- Reset mid-operation: after the loop, pulse reset between edges with w=1 wn=4 wd=99 -> rd for reg4 reads 0 immediately, rdv = 0. The edge during reset does not write. After deassert, the next edge writes 99.
- DEPTH=20: write wn=25 wd=7, read rn=25 -> rd = 0, rdv = 0. Regs 0..19 are unchanged.
